mem_bank_write_ctrl: RTL and testbench

Write-side front end for the multi-bank operator/channel state memories. It accepts register-bus writes through a valid/ready handshake and buffers them in a small FIFO. It issues them one per cycle onto the memory write port (`wea`/`banka`/`addra`/`dia`). After reset, or on request, it also sweeps every bank and address with a clear value.

---
 rtl/mem_bank_write_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_mem_bank_write_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bank_write_ctrl.sv
// mem_bank_write_ctrl: buffers register-bus writes onto a multi-bank memory write port and sweeps every location with CLEAR_VALUE after reset or on clear.
// Latency: accept-to-wea 2 cycles through the FIFO, 1 cycle on the bypass path when MEM_WRITE_CTRL_BYPASS_EN is defined.
// Backpressure: s_ready low while clearing/draining or with the FIFO full; the memory write port never stalls.
module mem_bank_write_ctrl #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    DEPTH       = 32,
    parameter int                    NUM_BANKS   = 2,
    parameter int                    BANK_WIDTH  = $clog2(NUM_BANKS),
    parameter int                    FIFO_DEPTH  = 4,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0,
    localparam int                   ADDR_WIDTH  = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    output logic                  busy,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [BANK_WIDTH-1:0] s_bank,
    input  logic [ADDR_WIDTH-1:0] s_addr,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  err_oor,
    output logic                  wea,
    output logic [BANK_WIDTH-1:0] banka,
    output logic [ADDR_WIDTH-1:0] addra,
    output logic [DATA_WIDTH-1:0] dia
);

`ifdef MEM_WRITE_CTRL_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [BANK_WIDTH:0]   NUM_BANKS_W = (BANK_WIDTH + 1)'(NUM_BANKS);
    localparam logic [ADDR_WIDTH:0]   DEPTH_W     = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [BANK_WIDTH-1:0] BANK_LAST   = BANK_WIDTH'(NUM_BANKS - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST   = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [CNT_W-1:0]      FIFO_FULL   = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [BANK_WIDTH-1:0] bank;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } wr_t;

    state_t                state_q, state_d;
    logic [BANK_WIDTH-1:0] bank_cnt_q, bank_cnt_d;
    logic [ADDR_WIDTH-1:0] addr_cnt_q, addr_cnt_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  wea_q, wea_d;
    logic [BANK_WIDTH-1:0] banka_q, banka_d;
    logic [ADDR_WIDTH-1:0] addra_q, addra_d;
    logic [DATA_WIDTH-1:0] dia_q, dia_d;
    logic                  err_oor_q, err_oor_d;

    wr_t  fifo_mem_q [FIFO_DEPTH];
    wr_t  req;
    logic accept;
    logic in_range;
    logic push;
    logic pop;

    assign req      = '{bank: s_bank, addr: s_addr, data: s_data};
    assign s_ready  = (state_q == ST_RUN) && (count_q < FIFO_FULL);
    assign accept   = s_valid && s_ready;
    // The comparisons are widened so non-power-of-two DEPTH/NUM_BANKS are checked exactly.
    assign in_range = ({1'b0, s_bank} < NUM_BANKS_W) && ({1'b0, s_addr} < DEPTH_W);

    assign busy    = (state_q != ST_RUN);
    assign err_oor = err_oor_q;
    assign wea     = wea_q;
    assign banka   = banka_q;
    assign addra   = addra_q;
    assign dia     = dia_q;

    // Next-state: clear sweep sequencing, FIFO push/pop and the write-port register.
    always_comb begin
        state_d    = state_q;
        bank_cnt_d = bank_cnt_q;
        addr_cnt_d = addr_cnt_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        wea_d      = 1'b0;
        banka_d    = banka_q;
        addra_d    = addra_q;
        dia_d      = dia_q;
        err_oor_d  = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;

        case (state_q)
            ST_CLEAR: begin
                wea_d   = 1'b1;
                banka_d = bank_cnt_q;
                addra_d = addr_cnt_q;
                dia_d   = CLEAR_VALUE;
                if (addr_cnt_q == ADDR_LAST) begin
                    addr_cnt_d = '0;
                    if (bank_cnt_q == BANK_LAST) begin
                        bank_cnt_d = '0;
                        state_d    = ST_RUN;
                    end else begin
                        bank_cnt_d = bank_cnt_q + BANK_WIDTH'(1);
                    end
                end else begin
                    addr_cnt_d = addr_cnt_q + ADDR_WIDTH'(1);
                end
            end
            ST_RUN, ST_DRAIN: begin
                if (count_q != '0) begin
                    pop      = 1'b1;
                    wea_d    = 1'b1;
                    banka_d  = fifo_mem_q[rd_ptr_q].bank;
                    addra_d  = fifo_mem_q[rd_ptr_q].addr;
                    dia_d    = fifo_mem_q[rd_ptr_q].data;
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                end
                // Out-of-range requests still complete the handshake; they are only flagged.
                if (accept) begin
                    if (!in_range) begin
                        err_oor_d = 1'b1;
                    end else if (BYPASS && (count_q == '0)) begin
                        wea_d   = 1'b1;
                        banka_d = s_bank;
                        addra_d = s_addr;
                        dia_d   = s_data;
                    end else begin
                        push     = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    end
                end
                count_d = count_q + CNT_W'(push) - CNT_W'(pop);
                // The last buffered write was loaded on an earlier edge, so an empty FIFO means drain is done.
                if ((state_q == ST_DRAIN) && (count_q == '0)) begin
                    state_d = ST_CLEAR;
                end else if ((state_q == ST_RUN) && clear) begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    // State and output registers; reset restarts the sweep and discards buffered writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_CLEAR;
            bank_cnt_q <= '0;
            addr_cnt_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            wea_q      <= 1'b0;
            banka_q    <= '0;
            addra_q    <= '0;
            dia_q      <= '0;
            err_oor_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bank_cnt_q <= bank_cnt_d;
            addr_cnt_q <= addr_cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            wea_q      <= wea_d;
            banka_q    <= banka_d;
            addra_q    <= addra_d;
            dia_q      <= dia_d;
            err_oor_q  <= err_oor_d;
        end
    end

    // FIFO storage needs no reset; the pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= req;
        end
    end

endmodule

// File: tb/tb_mem_bank_write_ctrl.sv
// Bench for mem_bank_write_ctrl with DEPTH=24 and NUM_BANKS=3, so that out-of-range
// bank (3) and address (24..31) values are representable on the request ports.
module tb_mem_bank_write_ctrl;
    localparam int DW    = 8;
    localparam int DEPTH = 24;
    localparam int NB    = 3;
    localparam int BW    = 2;
    localparam int AW    = 5;
    localparam int FD    = 4;
    localparam int SWEEP = NB * DEPTH;
    localparam logic [DW-1:0] CV = 8'h3C;
`ifdef MEM_WRITE_CTRL_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int LAT = BYP ? 1 : 2;

    logic          clk = 1'b0;
    logic          reset, clear, s_valid;
    logic [BW-1:0] s_bank;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_data;
    logic          busy, s_ready, err_oor, wea;
    logic [BW-1:0] banka;
    logic [AW-1:0] addra;
    logic [DW-1:0] dia;

    always #5 clk = ~clk;

    mem_bank_write_ctrl #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .NUM_BANKS  (NB),
        .BANK_WIDTH (BW),
        .FIFO_DEPTH (FD),
        .CLEAR_VALUE(CV)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear),
        .busy   (busy),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_bank (s_bank),
        .s_addr (s_addr),
        .s_data (s_data),
        .err_oor(err_oor),
        .wea    (wea),
        .banka  (banka),
        .addra  (addra),
        .dia    (dia)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct {
        int cyc;
        int bank;
        int addr;
        int data;
    } ent_t;

    localparam int P_SWEEP = 0;
    localparam int P_RUN   = 1;
    localparam int P_DRAIN = 2;

    int   m_phase = P_SWEEP;
    int   m_idx   = 0;
    ent_t m_q[$];
    bit   m_wea = 1'b0;
    bit   m_err = 1'b0;
    int   m_bank = 0, m_addr = 0, m_data = 0;
    bit   started = 1'b0;
    bit   m_acc, m_empty;
    ent_t m_r;

    function automatic void issue(input int b, input int a, input int d);
        m_wea  = 1'b1;
        m_bank = b;
        m_addr = a;
        m_data = d;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_phase = P_SWEEP;
            m_idx   = 0;
            m_q.delete();
            m_wea   = 1'b0;
            m_err   = 1'b0;
            m_bank  = 0;
            m_addr  = 0;
            m_data  = 0;
            started = 1'b1;
        end else if (started) begin
            m_acc = s_valid && (m_phase == P_RUN) && (m_q.size() < FD);
            m_wea = 1'b0;
            m_err = 1'b0;
            if (m_phase == P_SWEEP) begin
                issue(m_idx / DEPTH, m_idx % DEPTH, int'(CV));
                m_idx++;
                if (m_idx == SWEEP) begin
                    m_phase = P_RUN;
                    m_idx   = 0;
                end
            end else begin
                m_empty = (m_q.size() == 0);
                if (!m_empty) begin
                    m_r = m_q.pop_front();
                    issue(m_r.bank, m_r.addr, m_r.data);
                end
                if (m_acc) begin
                    m_r = '{0, int'(s_bank), int'(s_addr), int'(s_data)};
                    if (m_r.bank >= NB || m_r.addr >= DEPTH) m_err = 1'b1;
                    else if (BYP && m_empty) issue(m_r.bank, m_r.addr, m_r.data);
                    else m_q.push_back(m_r);
                end
                if (m_phase == P_DRAIN && m_empty) m_phase = P_SWEEP;
                else if (m_phase == P_RUN && clear) m_phase = P_DRAIN;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (started) begin
            chk("wea", wea, m_wea);
            chk("banka", banka, m_bank);
            chk("addra", addra, m_addr);
            chk("dia", dia, m_data);
            chk("err_oor", err_oor, m_err);
            chk("busy", busy, m_phase != P_RUN);
            chk("s_ready", s_ready, (m_phase == P_RUN) && (m_q.size() < FD));
        end
    end

    // ---------------- write log for directed literal checks ----------------
    int   cyc = 0;
    int   errcnt = 0;
    ent_t wlog[$];

    always @(posedge clk) begin
        cyc++;
        #1;
        if (wea === 1'b1) wlog.push_back('{cyc, int'(banka), int'(addra), int'(dia)});
        if (err_oor === 1'b1) errcnt++;
    end

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_sweep(input string tag, input int base, input int exp_first);
        int bad;
        bad = 0;
        if (wlog.size() < base + SWEEP) begin
            chk({tag, "_len"}, wlog.size(), base + SWEEP);
            return;
        end
        if (exp_first >= 0) chk({tag, "_start"}, wlog[base].cyc, exp_first);
        for (int i = 0; i < SWEEP; i++) begin
            if (wlog[base+i].bank != i / DEPTH || wlog[base+i].addr != i % DEPTH ||
                wlog[base+i].data != int'(CV) || wlog[base+i].cyc != wlog[base].cyc + i) bad++;
        end
        chk({tag, "_order"}, bad, 0);
    endtask

    int rel, acc, bad, e0;

    initial begin
        reset = 1'b1; clear = 1'b0; s_valid = 1'b0;
        s_bank = '0; s_addr = '0; s_data = '0;
        step();
        chk("rst_wea", wea, 0);
        chk("rst_busy", busy, 1);
        chk("rst_ready", s_ready, 0);
        chk("rst_err", err_oor, 0);
        chk("rst_bank_addr_dia", {banka, addra, dia}, 0);

        // Power-on sweep
        wlog.delete();
        rel = cyc;
        reset = 1'b0;
        step(SWEEP + 4);
        chk("sweep_cnt", wlog.size(), SWEEP);
        check_sweep("sweep", 0, rel + 1);
        chk("sweep_busy", busy, 0);
        chk("sweep_ready", s_ready, 1);

        // Single write
        wlog.delete();
        s_valid = 1'b1; s_bank = 2'd1; s_addr = 5'd5; s_data = 8'hA5;
        acc = cyc + 1;
        step();
        s_valid = 1'b0;
        step(5);
        chk("single_cnt", wlog.size(), 1);
        if (wlog.size() == 1) begin
            chk("single_cyc", wlog[0].cyc, acc + LAT - 1);
            chk("single_bank", wlog[0].bank, 1);
            chk("single_addr", wlog[0].addr, 5);
            chk("single_data", wlog[0].data, 8'hA5);
        end

        // Ten back-to-back writes
        wlog.delete();
        acc = cyc + 1;
        s_valid = 1'b1; s_bank = 2'd0;
        for (int i = 0; i < 10; i++) begin
            s_addr = AW'(i);
            s_data = DW'(i);
            chk("burst_ready", s_ready, 1);
            step();
        end
        s_valid = 1'b0;
        step(5);
        chk("burst_cnt", wlog.size(), 10);
        bad = 0;
        foreach (wlog[i]) if (wlog[i].data != i || wlog[i].addr != i || wlog[i].cyc != acc + LAT - 1 + i) bad++;
        chk("burst_order", bad, 0);

        // Out-of-range address, then out-of-range bank
        wlog.delete();
        e0 = errcnt;
        s_valid = 1'b1; s_bank = 2'd1; s_addr = 5'd28; s_data = 8'h77;
        step();
        s_valid = 1'b0;
        chk("oor_addr_pulse", err_oor, 1);
        step(4);
        chk("oor_addr_cnt", errcnt - e0, 1);
        e0 = errcnt;
        s_valid = 1'b1; s_bank = 2'd3; s_addr = 5'd0;
        step();
        s_valid = 1'b0;
        step(4);
        chk("oor_bank_cnt", errcnt - e0, 1);
        chk("oor_nowrite", wlog.size(), 0);

        // Three writes with clear on the third, then the sweep
        wlog.delete();
        s_valid = 1'b1; s_bank = 2'd2;
        s_addr = 5'd1; s_data = 8'h11; step();
        s_addr = 5'd2; s_data = 8'h22; step();
        s_addr = 5'd3; s_data = 8'h33; clear = 1'b1; step();
        s_valid = 1'b0; clear = 1'b0;
        chk("clr_busy", busy, 1);
        chk("clr_ready", s_ready, 0);
        step(SWEEP + 10);
        chk("clr_cnt", wlog.size(), 3 + SWEEP);
        bad = 0;
        for (int i = 0; i < 3 && i < wlog.size(); i++)
            if (wlog[i].bank != 2 || wlog[i].addr != i + 1 || wlog[i].data != 17 * (i + 1)) bad++;
        chk("clr_prefix", bad, 0);
        check_sweep("clr", 3, -1);
        chk("clr_done_busy", busy, 0);

        // Reset in the middle of a sweep
        reset = 1'b1; step(); reset = 1'b0;
        step(20);
        chk("mid_busy", busy, 1);
        wlog.delete();
        reset = 1'b1; step();
        rel = cyc;
        reset = 1'b0;
        step(SWEEP + 4);
        chk("mid_cnt", wlog.size(), SWEEP);
        check_sweep("mid", 0, rel + 1);

        // Randomised traffic with occasional clear and reset
        for (int n = 0; n < 3000; n++) begin
            s_valid = ($urandom_range(0, 2) != 0);
            s_bank  = BW'($urandom_range(0, 3));
            s_addr  = AW'($urandom_range(0, 31));
            s_data  = DW'($urandom);
            clear   = ($urandom_range(0, 149) == 0);
            reset   = ($urandom_range(0, 999) == 0);
            step();
        end
        s_valid = 1'b0; clear = 1'b0; reset = 1'b0;
        step(SWEEP + 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
